// File: rtl/spm_pkg.sv
// Shared types and sizes for the serial-parallel multiplier sequencer.
package spm_pkg;

  localparam int unsigned N  = 8;
  localparam int unsigned CW = 4;
  localparam int unsigned PW = 2 * N;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/spm_seq_ctrl_if.sv
// Handshake and data signals between the sequencer and its SPM array / comparator.
interface spm_seq_ctrl_if
  import spm_pkg::*;
#(
  parameter int unsigned N = spm_pkg::N
);

  logic             start;
  logic [N-1:0]     mplier;
  logic             cmp_hit;
  logic             p_bit;
  logic [CW-1:0]    cnt;
  logic             load;
  logic             shift_en;
  logic             y_bit;
  logic             busy;
  logic             done;
  logic [2*N-1:0]   product;

  modport master (
    output start, mplier, cmp_hit, p_bit,
    input  cnt, load, shift_en, y_bit, busy, done, product
  );

  modport slave (
    input  start, mplier, cmp_hit, p_bit,
    output cnt, load, shift_en, y_bit, busy, done, product
  );

endinterface

// File: rtl/spm_cnt4.sv
// Bit-step counter: cleared on load, advanced while the array shifts, wraps freely.
module spm_cnt4
  import spm_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] q
);

  logic [CW-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/spm_seq_ctrl.sv
// Sequencer for a serial-parallel multiplier: feeds multiplier bits LSB-first and
// collects the serial product until the external comparator flags the last step.
module spm_seq_ctrl
  import spm_pkg::*;
#(
  parameter int unsigned N = spm_pkg::N
) (
  input  logic clk,
  input  logic rst_n,
  spm_seq_ctrl_if.slave bus
);

  state_e         r_state;
  state_e         w_state_nxt;
  logic [N-1:0]   r_yreg;
  logic [2*N-1:0] r_product;
  logic           w_load;
  logic           w_shift_en;
  logic           w_done;
  logic           w_busy;
  logic           w_cnt_en;
  logic [CW-1:0]  w_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift_en  = 1'b0;
    w_done      = 1'b0;
    w_busy      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) w_state_nxt = LOAD;
      end
      LOAD: begin
        w_load      = 1'b1;
        w_busy      = 1'b1;
        w_state_nxt = RUN;
      end
      RUN: begin
        w_shift_en = 1'b1;
        w_busy     = 1'b1;
        if (bus.cmp_hit) w_state_nxt = DONE;
      end
      DONE: begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Multiplier register shifts arithmetically so steps N..2N-1 see its sign bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_yreg    <= '0;
      r_product <= '0;
    end else if (w_load) begin
      r_yreg    <= bus.mplier;
      r_product <= '0;
    end else if (w_shift_en) begin
      r_yreg    <= {r_yreg[N-1], r_yreg[N-1:1]};
      r_product <= {bus.p_bit, r_product[2*N-1:1]};
    end
  end

  // The terminal step still shifts, but the count stays at the value that hit.
  assign w_cnt_en = w_shift_en & ~bus.cmp_hit;

  spm_cnt4 u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_load),
    .en    (w_cnt_en),
    .q     (w_cnt)
  );

  assign bus.cnt      = w_cnt;
  assign bus.load     = w_load;
  assign bus.shift_en = w_shift_en;
  assign bus.y_bit    = w_shift_en & r_yreg[0];
  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.product  = r_product;

endmodule

// File: doc/spm_seq_ctrl.md
SPM_SEQ_CTRL -- requirements
Module: spm_seq_ctrl

Interface
REQ-001 Parameter N, default 8, SHALL set the operand width; product width is 2N and counter width is 4.
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on the rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: synchronous and active-low.
REQ-004 start  input  1  SHALL be the request to begin a multiplication; sampled only in IDLE.
REQ-005 mplier  input  N  SHALL be the signed multiplier, captured in LOAD.
REQ-006 cmp_hit  input  1  SHALL be the terminal-count flag from the downstream comparator (1 when cnt == 2N-1).
REQ-007 p_bit  input  1  SHALL be the serial product bit from the SPM array, LSB-first.
REQ-008 cnt  output  4  SHALL be the cycle count (Q) driven to the comparator.
REQ-009 load  output  1  SHALL instruct the SPM array to load the multiplicand and clear its carries.
REQ-010 shift_en  output  1  SHALL enable the SPM array for one bit-step.
REQ-011 y_bit  output  1  SHALL be the serial multiplier bit presented to the array.
REQ-012 busy  output  1  SHALL be high in LOAD and RUN.
REQ-013 done  output  1  SHALL be a one-cycle pulse marking product valid.
REQ-014 product  output  2N  SHALL be the signed product register.

Function
REQ-015 The FSM SHALL have four states: IDLE, LOAD, RUN and DONE.
REQ-016 IDLE -> LOAD when start=1; otherwise the FSM SHALL stay in IDLE.
REQ-017 LOAD SHALL last one cycle and then go to RUN.
REQ-018 In LOAD, the block SHALL set load=1, cnt<=0, yreg<=mplier and product<=0.
REQ-019 In RUN, the block SHALL set shift_en=1 and y_bit=yreg[0].
REQ-020 In each RUN cycle, yreg SHALL arithmetic-shift right, so the sign bit is replicated for steps N..2N-1.
REQ-021 In each RUN cycle, product SHALL update as product <= {p_bit, product[2N-1:1]}.
REQ-022 In RUN with cmp_hit=0, cnt SHALL increment modulo 16 and the FSM SHALL remain in RUN.
REQ-023 In RUN with cmp_hit=1, the block SHALL take the final shift, hold cnt, and go to DONE.
REQ-024 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-025 Nominal latency: start sampled in cycle 0 gives LOAD in cycle 1, RUN in cycles 2..17 and done in cycle 18.
REQ-026 product SHALL hold its value from DONE until the next LOAD.
REQ-027 start asserted in LOAD, RUN or DONE SHALL be ignored and SHALL NOT be queued.
REQ-028 cmp_hit SHALL be ignored outside RUN.
REQ-029 If cmp_hit is asserted early, the FSM SHALL still go to DONE; product then holds a partial result with no error flag.
REQ-030 If cmp_hit never asserts, cnt SHALL wrap 15->0 and RUN SHALL continue; there is no internal timeout.
REQ-031 load, shift_en and done SHALL be mutually exclusive and decoded from state only (Moore outputs).

Reset
REQ-032 rst_n=0 at a clock edge SHALL force IDLE from any state, including mid-RUN.
REQ-033 Reset values SHALL be cnt=0, yreg=0, product=0, load=0, shift_en=0, y_bit=0, busy=0 and done=0.
REQ-034 start SHALL be honoured in the first cycle after rst_n returns high.

Structure
REQ-035 Shared package spm_pkg SHALL hold the state enum (IDLE, LOAD, RUN, DONE), N=8, CW=4 and PW=2N.
REQ-036 The 4-bit counter SHALL be a sub-module spm_cnt4 with ports clk, rst_n, clr, en and q.
REQ-037 The FSM, yreg and product register SHALL be in spm_seq_ctrl.
REQ-038 The comparator and SPM array SHALL remain external.

Verification (bench contains behavioural SPM array model and comparator fixed at 15)
REQ-039 mplier=5, mcand=3, start pulse -> done in cycle 18, product=0x000F, busy high for cycles 1..17.
REQ-040 mplier=-128, mcand=-128 -> product=0x4000; mplier=1, mcand=-1 -> product=0xFFFF.
REQ-041 start held high during RUN, and again in DONE -> exactly one done pulse; FSM returns to IDLE.
REQ-042 rst_n=0 at RUN cycle 5 -> next cycle IDLE with all outputs zero; a new start then gives a correct product.
REQ-043 cmp_hit forced high when cnt=3 -> DONE after 4 RUN cycles and cnt holds 3.
REQ-044 cmp_hit tied low -> cnt wraps 15->0, shift_en stays high and done is never asserted.
